// File: rtl/audio_pkg.sv
// Shared types for the stereo boxcar filter.
// Sample width, FSM state encoding and sample type.
package audio_pkg;

    localparam int DW = 24;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2,
        S_WR   = 2'd3
    } state_t;

    typedef logic signed [DW-1:0] sample_t;

endpackage

// File: rtl/audio_avg_filter_channel.sv
// One channel of the moving-average filter: N-entry delay
// line, write pointer and running-sum accumulator.
module avg_channel
    import audio_pkg::*;
#(
    parameter int DW     = audio_pkg::DW,
    parameter int LOG2_N = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic signed [DW-1:0] samp,
    output logic signed [DW-1:0] avg
);

    localparam int N  = 1 << LOG2_N;
    localparam int AW = DW + LOG2_N;

    logic signed [DW-1:0]     dly_q [N];
    logic        [LOG2_N-1:0] wptr_q;
    logic signed [AW-1:0]     acc_q;
    logic signed [AW-1:0]     acc_d;
    logic signed [AW-1:0]     samp_x;
    logic signed [AW-1:0]     old_x;

    // Running sum of the window after replacing the oldest sample.
    always_comb begin
        samp_x = $signed({{LOG2_N{samp[DW-1]}}, samp});
        old_x  = $signed({{LOG2_N{dly_q[wptr_q][DW-1]}}, dly_q[wptr_q]});
        acc_d  = acc_q + samp_x - old_x;
        avg    = acc_d[AW-1:LOG2_N];
    end

    // Commit the new sample into the window on the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                dly_q[i] <= '0;
            end
            wptr_q <= '0;
            acc_q  <= '0;
        end else if (en) begin
            dly_q[wptr_q] <= samp;
            wptr_q        <= wptr_q + LOG2_N'(1);
            acc_q         <= acc_d;
        end
    end

endmodule

// File: rtl/audio_avg_filter.sv
// Stereo boxcar low-pass between codec read and write sides.
// Pops one sample, averages the last N, pushes the result.
module audio_avg_filter
    import audio_pkg::*;
#(
    parameter int LOG2_N = 3,
    parameter int DW     = audio_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bypass,
    input  logic          in_valid,
    input  logic [DW-1:0] in_left,
    input  logic [DW-1:0] in_right,
    output logic          in_read,
    input  logic          out_ready,
    output logic [DW-1:0] out_left,
    output logic [DW-1:0] out_right,
    output logic          out_write
);

    state_t               state_q;
    logic                 in_read_q;
    logic                 out_write_q;
    logic signed [DW-1:0] samp_l_q;
    logic signed [DW-1:0] samp_r_q;
    logic        [DW-1:0] out_l_q;
    logic        [DW-1:0] out_r_q;
    logic signed [DW-1:0] avg_l;
    logic signed [DW-1:0] avg_r;
    logic                 acc_en;

    assign acc_en    = (state_q == S_ACC);
    assign in_read   = in_read_q;
    assign out_write = out_write_q;
    assign out_left  = out_l_q;
    assign out_right = out_r_q;

    avg_channel #(
        .DW     (DW),
        .LOG2_N (LOG2_N)
    ) u_left (
        .clk   (clk),
        .reset (reset),
        .en    (acc_en),
        .samp  (samp_l_q),
        .avg   (avg_l)
    );

    avg_channel #(
        .DW     (DW),
        .LOG2_N (LOG2_N)
    ) u_right (
        .clk   (clk),
        .reset (reset),
        .en    (acc_en),
        .samp  (samp_r_q),
        .avg   (avg_r)
    );

    // Handshake FSM: pop, accumulate, hold result, push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_read_q   <= 1'b0;
            out_write_q <= 1'b0;
            samp_l_q    <= '0;
            samp_r_q    <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        samp_l_q  <= in_left;
                        samp_r_q  <= in_right;
                        in_read_q <= 1'b1;
                        state_q   <= S_ACC;
                    end
                end
                S_ACC: begin
                    in_read_q <= 1'b0;
                    out_l_q   <= bypass ? samp_l_q : avg_l;
                    out_r_q   <= bypass ? samp_r_q : avg_r;
                    state_q   <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_write_q <= 1'b1;
                        state_q     <= S_WR;
                    end
                end
                S_WR: begin
                    out_write_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_avg_filter.sv
// Directed scoreboard bench for audio_avg_filter.
// Expected outputs come from a window-sum model in the bench.
module tb_audio_avg_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic        bypass;
    logic        in_valid;
    logic [23:0] in_left;
    logic [23:0] in_right;
    logic        in_read;
    logic        out_ready;
    logic [23:0] out_left;
    logic [23:0] out_right;
    logic        out_write;

    int checks = 0;
    int fails  = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    logic [23:0]        ql[$];
    logic [23:0]        qr[$];
    logic signed [23:0] hl[8];
    logic signed [23:0] hr[8];
    int                 hidx;

    always #5 clk = ~clk;

    audio_avg_filter #(
        .LOG2_N (3),
        .DW     (24)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bypass    (bypass),
        .in_valid  (in_valid),
        .in_left   (in_left),
        .in_right  (in_right),
        .in_read   (in_read),
        .out_ready (out_ready),
        .out_left  (out_left),
        .out_right (out_right),
        .out_write (out_write)
    );

    task automatic chk(input string tag, input logic [23:0] obs,
                       input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 8; j++) begin
            hl[j] = '0;
            hr[j] = '0;
        end
        hidx = 0;
        ql.delete();
        qr.delete();
    endtask

    // Reference: full window sum recomputed every sample.
    task automatic push_exp(input logic [23:0] l, input logic [23:0] r,
                            input logic bp);
        int sl;
        int sr;
        int tl;
        int tr;
        hl[hidx] = l;
        hr[hidx] = r;
        hidx = (hidx + 1) % 8;
        sl = 0;
        sr = 0;
        for (int j = 0; j < 8; j++) begin
            sl += int'(hl[j]);
            sr += int'(hr[j]);
        end
        tl = sl >>> 3;
        tr = sr >>> 3;
        ql.push_back(bp ? l : tl[23:0]);
        qr.push_back(bp ? r : tr[23:0]);
    endtask

    // Scoreboard side: pop and compare on every push pulse.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (in_read === 1'b1) rd_cnt++;
            if (out_write === 1'b1) begin
                wr_cnt++;
                if (ql.size() == 0) begin
                    chk("sb_empty", 24'd1, 24'd0);
                end else begin
                    chk("sb_left", out_left, ql.pop_front());
                    chk("sb_right", out_right, qr.pop_front());
                end
            end
        end
    end

    task automatic wait_rd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (in_read !== 1'b1 && n < 60);
        if (in_read !== 1'b1) chk("timeout_rd", 24'd0, 24'd1);
    endtask

    task automatic wait_wr();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_write !== 1'b1 && n < 60);
        if (out_write !== 1'b1) chk("timeout_wr", 24'd0, 24'd1);
    endtask

    // One sample through the filter; returns on the push cycle.
    task automatic send(input logic [23:0] l, input logic [23:0] r,
                        input logic bp, input bit lat);
        int n;
        int m;
        @(negedge clk);
        in_left  = l;
        in_right = r;
        bypass   = bp;
        in_valid = 1'b1;
        push_exp(l, r, bp);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (in_read !== 1'b1 && n < 60);
        in_valid = 1'b0;
        if (in_read !== 1'b1) chk("timeout_rd", 24'd0, 24'd1);
        if (lat) chk("lat_rd", 24'(n), 24'd1);
        m = 0;
        do begin
            @(negedge clk);
            if (lat && m == 0) chk("rd_pulse", {23'd0, in_read}, 24'd0);
            m++;
        end while (out_write !== 1'b1 && m < 60);
        if (out_write !== 1'b1) chk("timeout_wr", 24'd0, 24'd1);
        if (lat) chk("lat_wr", 24'(n + m), 24'd3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int          rd0;
        int          wr0;
        int          v;
        logic [23:0] hold_l;
        logic [23:0] hold_r;

        reset     = 1'b1;
        bypass    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_left   = '0;
        in_right  = '0;
        model_reset();
        @(negedge clk);
        #2 reset = 1'b0;

        // Async reset while a push is in flight.
        send(24'd500, 24'd300, 1'b0, 1'b1);
        chk("pre_rst_wr", {23'd0, out_write}, 24'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_rd", {23'd0, in_read}, 24'd0);
        chk("rst_wr", {23'd0, out_write}, 24'd0);
        chk("rst_l", out_left, 24'd0);
        chk("rst_r", out_right, 24'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();

        // Step response.
        for (int i = 1; i <= 12; i++) begin
            send(24'd800, -24'sd800, 1'b0, 1'b1);
            v = (i < 8) ? 100 * i : 800;
            chk("step_l", out_left, v[23:0]);
            v = -v;
            chk("step_r", out_right, v[23:0]);
        end

        // Impulse: exactly eight outputs carry it.
        do_reset();
        send(24'h7FFFFF, 24'd0, 1'b0, 1'b0);
        chk("imp_l", out_left, 24'h0FFFFF);
        for (int i = 1; i < 11; i++) begin
            send(24'd0, 24'd0, 1'b0, 1'b0);
            chk("imp_l", out_left, (i < 8) ? 24'h0FFFFF : 24'h000000);
        end

        // Backpressure with in_valid held.
        @(negedge clk);
        #1;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        out_ready = 1'b0;
        in_left   = 24'h001234;
        in_right  = 24'hFFF000;
        in_valid  = 1'b1;
        push_exp(in_left, in_right, 1'b0);
        repeat (3) @(negedge clk);
        hold_l = out_left;
        hold_r = out_right;
        repeat (20) @(negedge clk);
        #1;
        chk("bp_rd", 24'(rd_cnt - rd0), 24'd1);
        chk("bp_wr", 24'(wr_cnt - wr0), 24'd0);
        chk("bp_hold_l", out_left, hold_l);
        chk("bp_hold_r", out_right, hold_r);
        out_ready = 1'b1;
        wait_wr();
        wait_rd();
        #1;
        chk("bp_wr1", 24'(wr_cnt - wr0), 24'd1);
        chk("bp_rd2", 24'(rd_cnt - rd0), 24'd2);
        in_valid = 1'b0;
        push_exp(in_left, in_right, 1'b0);
        wait_wr();

        // Bypass over a full window.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(24'h000100, 24'h000100, 1'b0, 1'b0);
        end
        send(24'h123456, 24'h123456, 1'b1, 1'b0);
        chk("byp_on", out_left, 24'h123456);
        send(24'h000100, 24'h000100, 1'b0, 1'b0);
        v = (7 * 'h100 + 'h123456) >>> 3;
        chk("byp_off", out_left, v[23:0]);

        // Reset while the result is held.
        @(negedge clk);
        out_ready = 1'b0;
        in_left   = 24'h000777;
        in_right  = 24'h000777;
        in_valid  = 1'b1;
        wait_rd();
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        wr0 = wr_cnt;
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_l", out_left, 24'd0);
        chk("mid_rst_wr", {23'd0, out_write}, 24'd0);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("mid_rst_nowr", 24'(wr_cnt - wr0), 24'd0);
        send(24'd800, 24'd800, 1'b0, 1'b1);
        chk("mid_rst_hist", out_left, 24'd100);

        @(negedge clk);
        #1;
        chk("sb_drained", 24'(ql.size()), 24'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
